// File: rtl/mult_accum.sv
// mult_accum: sums a fixed-length frame of CNT unsigned products from the
// upstream multiplier into an AW-bit register (wrapping modulo 2^AW) and
// offers the frame total, with a sticky per-frame overflow flag, on a
// valid/ready output. clear aborts the current frame or drops a held result.
module mult_accum #(
  parameter int PW  = 4,
  parameter int AW  = 8,
  parameter int CNT = 4,
  localparam int CW = $clog2(CNT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] acc_out,
  output logic          overflow,
  output logic [CW-1:0] count
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [AW-1:0]   acc_r;
  logic            ovf_r;
  logic [CW-1:0]   count_r;
  logic [AW-1:0]   acc_out_r;
  logic            overflow_r;
  logic [AW:0]     sum_s;
  logic            accept_s;
  logic            last_s;

  // Full-width add keeps the carry so it can feed the sticky overflow flag.
  function automatic logic [AW:0] add_ext(input logic [AW-1:0] a, input logic [PW-1:0] b);
    return {1'b0, a} + {{(AW + 1 - PW){1'b0}}, b};
  endfunction

  // Handshake decode and the running sum of the current frame.
  always_comb begin
    sum_s    = add_ext(acc_r, prod);
    accept_s = in_valid & (state_r == ST_ACC);
    last_s   = (count_r == CW'(CNT - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_ACC;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: clear always returns to collecting.
  always_comb begin
    state_next_s = state_r;
    if (clear) begin
      state_next_s = ST_ACC;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (accept_s && last_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ACC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_next_s = ST_ACC;
          end else begin
            state_next_s = ST_DONE;
          end
        end
        default: state_next_s = ST_ACC;
      endcase
    end
  end

  // Accumulator, sticky flag, product counter and the held frame result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= '0;
      ovf_r      <= 1'b0;
      count_r    <= '0;
      acc_out_r  <= '0;
      overflow_r <= 1'b0;
    end else if (clear) begin
      acc_r      <= '0;
      ovf_r      <= 1'b0;
      count_r    <= '0;
      acc_out_r  <= '0;
      overflow_r <= 1'b0;
    end else if (accept_s) begin
      if (last_s) begin
        acc_out_r  <= sum_s[AW-1:0];
        overflow_r <= ovf_r | sum_s[AW];
        acc_r      <= '0;
        ovf_r      <= 1'b0;
        count_r    <= '0;
      end else begin
        acc_r      <= sum_s[AW-1:0];
        ovf_r      <= ovf_r | sum_s[AW];
        count_r    <= count_r + CW'(1);
      end
    end else begin
      acc_r      <= acc_r;
      ovf_r      <= ovf_r;
      count_r    <= count_r;
      acc_out_r  <= acc_out_r;
      overflow_r <= overflow_r;
    end
  end

  // Outputs come straight from registered state, no input-to-output path.
  assign in_ready  = (state_r == ST_ACC);
  assign out_valid = (state_r == ST_DONE);
  assign acc_out   = acc_out_r;
  assign overflow  = overflow_r;
  assign count     = count_r;

endmodule

// File: tb/tb_mult_accum.sv
// Directed bench for mult_accum: a default instance (AW=8, CNT=4) and a
// narrow instance (AW=5) for the wrap/overflow frames.
module tb_mult_accum;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] prod;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] acc_out;
  logic       overflow;
  logic [2:0] count;

  logic       clear5;
  logic       in_valid5;
  logic       in_ready5;
  logic [3:0] prod5;
  logic       out_valid5;
  logic       out_ready5;
  logic [4:0] acc_out5;
  logic       overflow5;
  logic [2:0] count5;

  int checks;
  int errors;

  mult_accum dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .overflow(overflow), .count(count)
  );

  mult_accum #(.PW(4), .AW(5), .CNT(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .clear(clear5), .in_valid(in_valid5), .in_ready(in_ready5),
    .prod(prod5), .out_valid(out_valid5), .out_ready(out_ready5), .acc_out(acc_out5),
    .overflow(overflow5), .count(count5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a product on the default instance and return one edge after it is taken.
  task automatic push(input logic [3:0] v);
    logic rdy;
    int   n;
    in_valid = 1'b1;
    prod     = v;
    rdy      = 1'b0;
    n        = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL push_timeout in_ready never high for prod %0d", v);
    end
  endtask

  // Same as push, for the narrow instance.
  task automatic push5(input logic [3:0] v);
    logic rdy;
    int   n;
    in_valid5 = 1'b1;
    prod5     = v;
    rdy       = 1'b0;
    n         = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = in_ready5;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL push5_timeout in_ready never high for prod %0d", v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; prod = 4'd0; out_ready = 1'b1;
    clear5 = 1'b0; in_valid5 = 1'b0; prod5 = 4'd0; out_ready5 = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0d exp 0", out_valid); end
    checks++; if (acc_out !== 8'd0) begin errors++; $display("FAIL rst_acc_out got %0d exp 0", acc_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0d exp 0", overflow); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0d exp 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sum();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prod      = 4'd9;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin
        checks++;
        if (count !== 3'(i + 1)) begin errors++; $display("FAIL sum_count got %0d exp %0d", count, i + 1); end
      end
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sum_out_valid got %0d exp 1", out_valid); end
    checks++; if (acc_out !== 8'd36) begin errors++; $display("FAIL sum_acc_out got %0d exp 36", acc_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sum_overflow got %0d exp 0", overflow); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sum_in_ready_done got %0d exp 0", in_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL sum_count_done got %0d exp 0", count); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sum_pulse_len got %0d exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sum_in_ready_back got %0d exp 1", in_ready); end
  endtask

  task automatic test_wrap();
    out_ready5 = 1'b1;
    for (int i = 0; i < 4; i++) push5(4'd9);
    in_valid5 = 1'b0;
    checks++; if (out_valid5 !== 1'b1) begin errors++; $display("FAIL wrap_out_valid got %0d exp 1", out_valid5); end
    checks++; if (acc_out5 !== 5'd4) begin errors++; $display("FAIL wrap_acc_out got %0d exp 4", acc_out5); end
    checks++; if (overflow5 !== 1'b1) begin errors++; $display("FAIL wrap_overflow got %0d exp 1", overflow5); end
    push5(4'd1); push5(4'd0); push5(4'd2); push5(4'd0);
    in_valid5 = 1'b0;
    checks++; if (acc_out5 !== 5'd3) begin errors++; $display("FAIL wrap2_acc_out got %0d exp 3", acc_out5); end
    checks++; if (overflow5 !== 1'b0) begin errors++; $display("FAIL wrap2_overflow got %0d exp 0", overflow5); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(4'd1); push(4'd2); push(4'd3); push(4'd4);
    prod = 4'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %0d exp 1", i, out_valid); end
      checks++; if (acc_out !== 8'd10) begin errors++; $display("FAIL bp_acc_out cyc %0d got %0d exp 10", i, acc_out); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL bp_count cyc %0d got %0d exp 0", i, count); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %0d exp 1", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL bp_first_accept got %0d exp 1", count); end
    push(4'd0); push(4'd0); push(4'd0);
    in_valid = 1'b0;
    checks++; if (acc_out !== 8'd6) begin errors++; $display("FAIL bp_next_frame got %0d exp 6", acc_out); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    push(4'd4); push(4'd4);
    clear = 1'b1; prod = 4'd9;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", count); end
    push(4'd1); push(4'd1); push(4'd1); push(4'd1);
    in_valid = 1'b0;
    checks++; if (acc_out !== 8'd4) begin errors++; $display("FAIL clr_acc_out got %0d exp 4", acc_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %0d exp 0", overflow); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_clear_done();
    out_ready = 1'b0;
    push(4'd5); push(4'd5); push(4'd5); push(4'd5);
    in_valid = 1'b0;
    checks++; if (acc_out !== 8'd20) begin errors++; $display("FAIL clrd_pre got %0d exp 20", acc_out); end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clrd_out_valid got %0d exp 0", out_valid); end
    checks++; if (acc_out !== 8'd0) begin errors++; $display("FAIL clrd_acc_out got %0d exp 0", acc_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clrd_in_ready got %0d exp 1", in_ready); end
    push(4'd1); push(4'd1); push(4'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL clrc_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clrc_out_valid got %0d exp 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'd9);
    in_valid = 1'b0;
    checks++; if (acc_out !== 8'd36) begin errors++; $display("FAIL ar_pre got %0d exp 36", acc_out); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got %0d exp 0", out_valid); end
    checks++; if (acc_out !== 8'd0) begin errors++; $display("FAIL ar_acc_out got %0d exp 0", acc_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ar_overflow got %0d exp 0", overflow); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", count); end
    #4;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready got %0d exp 1", in_ready); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle_gaps();
    logic [3:0] vals [4];
    int gap;
    vals[0] = 4'd2; vals[1] = 4'd0; vals[2] = 4'd3; vals[3] = 4'd1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        checks++;
        if (count !== 3'(i)) begin errors++; $display("FAIL gap_count_idle got %0d exp %0d", count, i); end
      end
      push(vals[i]);
      checks++;
      if (count !== 3'((i + 1) % 4)) begin errors++; $display("FAIL gap_count_step got %0d exp %0d", count, (i + 1) % 4); end
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_out_valid got %0d exp 1", out_valid); end
    checks++; if (acc_out !== 8'd6) begin errors++; $display("FAIL gap_acc_out got %0d exp 6", acc_out); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sum();
    test_wrap();
    test_backpressure();
    test_clear();
    test_clear_done();
    test_async_reset();
    test_idle_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
